// File: rtl/rand_range.sv
// Bounded random value generator: reduces a 13-bit LFSR word modulo an 8-bit limit
// with a serial restoring divider, and never returns the same value twice in a row.
module rand_range (
    input  logic        clock,
    input  logic        reset,
    input  logic [12:0] rnd,
    input  logic        req,
    input  logic [7:0]  limit,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ack,
    output logic [7:0]  out_val,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [12:0] r_dividend;
    logic [7:0]  r_divisor;
    logic [3:0]  r_step;
    logic [8:0]  r_rem;
    logic [7:0]  r_prev;
    logic        r_prev_valid;
    logic        r_busy;
    logic        r_out_valid;
    logic [7:0]  r_out_val;
    logic        r_err;

    logic [3:0]  w_idx;
    logic        w_bit;
    logic [8:0]  w_t;
    logic [8:0]  w_rem_next;
    logic [7:0]  w_rem8;
    logic [7:0]  w_inc;
    logic        w_hit;
    logic [7:0]  w_result;

    // One restoring-division step per CALC cycle, dividend consumed MSB first.
    always_comb begin
        w_idx      = 4'd12 - r_step;
        w_bit      = r_dividend[w_idx];
        w_t        = {r_rem[7:0], w_bit};
        w_rem_next = (w_t >= {1'b0, r_divisor}) ? (w_t - {1'b0, r_divisor}) : w_t;
    end

    // Remainder is always below the divisor here, so +1 cannot overflow 8 bits.
    always_comb begin
        w_rem8   = r_rem[7:0];
        w_inc    = w_rem8 + 8'd1;
        w_hit    = r_prev_valid && (r_divisor >= 8'd2) && (w_rem8 == r_prev);
        w_result = w_rem8;
        if (w_hit)
            w_result = (w_inc == r_divisor) ? 8'd0 : w_inc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_step       <= '0;
            r_rem        <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_val    <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_dividend <= rnd;
                        r_divisor  <= limit;
                        r_step     <= '0;
                        r_rem      <= '0;
                        r_busy     <= 1'b1;
                        // A zero bound has no valid result; report it without touching history.
                        if (limit == 8'd0) begin
                            r_state     <= DONE;
                            r_out_val   <= '0;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem  <= w_rem_next;
                    r_step <= r_step + 4'd1;
                    if (r_step == 4'd12)
                        r_state <= ADJ;
                end
                ADJ: begin
                    r_out_val    <= w_result;
                    r_err        <= 1'b0;
                    r_prev       <= w_result;
                    r_prev_valid <= 1'b1;
                    r_out_valid  <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    if (out_ack) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_val   = r_out_val;
    assign err       = r_err;

endmodule

// File: tb/tb_rand_range.sv
// Directed bench for rand_range: hand-computed modulo / no-repeat results, latency,
// handshake and mid-operation reset.
module tb_rand_range;

    logic        clock;
    logic        reset;
    logic [12:0] rnd;
    logic        req;
    logic [7:0]  limit;
    logic        busy;
    logic        out_valid;
    logic        out_ack;
    logic [7:0]  out_val;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;

    rand_range dut (
        .clock    (clock),
        .reset    (reset),
        .rnd      (rnd),
        .req      (req),
        .limit    (limit),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .out_val  (out_val),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present a one-cycle request; lat counts edges from the accepting edge (1 = that edge).
    task automatic start(input logic [12:0] r, input logic [7:0] l);
        @(negedge clock);
        rnd   = r;
        limit = l;
        req   = 1'b1;
        @(posedge clock); #1;
        req = 1'b0;
        lat = 1;
    endtask

    task automatic wait_valid;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int exp_lat,
                                input logic [7:0] ev, input logic ee);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".val"}, out_val, ev);
        check({tag, ".err"}, err, ee);
        check({tag, ".busy"}, busy, 1'b1);
    endtask

    task automatic ack(input string tag);
        @(negedge clock);
        out_ack = 1'b1;
        @(posedge clock); #1;
        out_ack = 1'b0;
        check({tag, ".ack_vld"}, out_valid, 1'b0);
        check({tag, ".ack_busy"}, busy, 1'b0);
    endtask

    task automatic run(input string tag, input logic [12:0] r, input logic [7:0] l,
                       input int exp_lat, input logic [7:0] ev, input logic ee);
        start(r, l);
        wait_valid();
        check_result(tag, exp_lat, ev, ee);
        ack(tag);
    endtask

    initial begin
        reset   = 1'b1;
        rnd     = '0;
        req     = 1'b0;
        limit   = '0;
        out_ack = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst.busy", busy, 1'b0);
        check("rst.vld", out_valid, 1'b0);
        check("rst.val", out_val, 8'd0);
        check("rst.err", err, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // 6844 mod 10 = 4, then outputs hold while unacknowledged
        start(13'h1ABC, 8'd10);
        wait_valid();
        check_result("basic", 15, 8'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("basic.hold_vld", out_valid, 1'b1);
            check("basic.hold_val", out_val, 8'd4);
        end
        ack("basic");

        run("max128", 13'h1FFF, 8'd128, 15, 8'd127, 1'b0);
        run("zero255", 13'h0000, 8'd255, 15, 8'd0, 1'b0);
        // remainder 0 equals prev 0, but limit 1 never adjusts
        run("lim1", 13'd1234, 8'd1, 15, 8'd0, 1'b0);

        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst2.vld", out_valid, 1'b0);

        run("nr1", 13'd20, 8'd7, 15, 8'd6, 1'b0);
        run("lim0", 13'd5, 8'd0, 1, 8'd0, 1'b1);
        @(posedge clock); #1;
        check("lim0.idle_err", err, 1'b1);
        check("lim0.idle_val", out_val, 8'd0);
        // raw 6 == prev 6 (untouched by the zero-limit result) -> wraps to 0
        run("nr2", 13'd27, 8'd7, 15, 8'd0, 1'b0);
        run("nr3", 13'd9, 8'd7, 15, 8'd2, 1'b0);
        run("nr4", 13'd16, 8'd7, 15, 8'd3, 1'b0);

        // req, ack and new operands during CALC must not disturb 50 mod 11 = 6
        start(13'd50, 8'd11);
        @(posedge clock); #1; lat++;
        @(posedge clock); #1; lat++;
        rnd = 13'd0; limit = 8'd3; req = 1'b1; out_ack = 1'b1;
        @(posedge clock); #1; lat++;
        req = 1'b0; out_ack = 1'b0;
        check("inflight.busy", busy, 1'b1);
        wait_valid();
        check_result("inflight", 15, 8'd6, 1'b0);
        ack("inflight");

        // req held high: one result per ack; 100 mod 9 = 1, then repeat -> 2
        @(negedge clock);
        rnd = 13'd100; limit = 8'd9; req = 1'b1;
        @(posedge clock); #1;
        lat = 1;
        wait_valid();
        check_result("held1", 15, 8'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("held1.hold_vld", out_valid, 1'b1);
        end
        @(negedge clock); out_ack = 1'b1;
        @(posedge clock); #1;
        out_ack = 1'b0;
        check("held.ack_vld", out_valid, 1'b0);
        check("held.ack_busy", busy, 1'b0);
        @(posedge clock); #1;
        lat = 1;
        check("held.reaccept", busy, 1'b1);
        wait_valid();
        check_result("held2", 15, 8'd2, 1'b0);
        req = 1'b0;
        ack("held2");
        @(posedge clock); #1;
        check("noqueue.busy", busy, 1'b0);

        // abort at CALC step 5; the retry sees no history, so 9 mod 7 stays 2
        start(13'd9, 8'd7);
        repeat (5) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst.busy", busy, 1'b0);
        check("midrst.vld", out_valid, 1'b0);
        check("midrst.val", out_val, 8'd0);
        run("postrst", 13'd9, 8'd7, 15, 8'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
